online_to_binary_serial: RTL

ONLINE_TO_BINARY_SERIAL -- requirements
Module: online_to_binary_serial

---
 rtl/online_to_binary_serial_if.sv | 13 +
 rtl/online_to_binary_serial.sv | 78 +++++++
 2 files changed

// File: rtl/online_to_binary_serial_if.sv
// Conversion handshake: start pulse, qualified signed-digit stream in; result and status out.
interface online_to_binary_serial_if #(parameter int no_of_digits = 8);
  logic                  start;
  logic                  din_valid;
  logic                  dinp;
  logic                  dinn;
  logic [no_of_digits:0] dout;
  logic                  busy;
  logic                  finish;

  modport master (output start, din_valid, dinp, dinn, input dout, busy, finish);
  modport slave  (input start, din_valid, dinp, dinn, output dout, busy, finish);
endinterface

// File: rtl/online_to_binary_serial.sv
// Serial MSB-first radix-2 signed-digit to two's-complement converter (on-the-fly Q/QM).
// Result lands on the same edge as the last digit; din_valid low simply stalls the conversion.
module online_to_binary_serial #(
  parameter int no_of_digits = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  online_to_binary_serial_if.slave     bus
);
  localparam int W  = no_of_digits + 1;
  localparam int CW = $clog2(no_of_digits + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [W-1:0]   q, qm, q_next, qm_next;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   dout;
  logic           busy, finish;
  logic           dig_pos, dig_neg;

  assign dig_pos = bus.dinp & ~bus.dinn;
  assign dig_neg = bus.dinn & ~bus.dinp;

  // Appending a digit: both candidates are left shifts of Q or QM with a 0/1 fill.
  always_comb begin
    q_next  = {q[W-2:0], 1'b0};
    qm_next = {qm[W-2:0], 1'b1};
    if (dig_pos) begin
      q_next  = {q[W-2:0], 1'b1};
      qm_next = {q[W-2:0], 1'b0};
    end else if (dig_neg) begin
      q_next  = {qm[W-2:0], 1'b1};
      qm_next = {qm[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      q      <= '0;
      qm     <= '1;
      cnt    <= '0;
      dout   <= '0;
      busy   <= 1'b0;
      finish <= 1'b0;
    end else if (bus.start) begin
      state  <= RUN;
      q      <= '0;
      qm     <= '1;
      cnt    <= '0;
      busy   <= 1'b1;
      finish <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (bus.din_valid) begin
            q  <= q_next;
            qm <= qm_next;
            if (cnt == CW'(no_of_digits - 1)) begin
              dout   <= q_next;
              finish <= 1'b1;
              busy   <= 1'b0;
              state  <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.dout   = dout;
  assign bus.busy   = busy;
  assign bus.finish = finish;
endmodule
